bcd_converter: RTL and testbench

//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) on the
//   CPU-side chip-select/write bus. Sits directly upstream of the 7-segment hex

---
 rtl/bcd_converter.sv | 124 ++++++++++++
 tb/tb_bcd_converter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_converter.sv
// Purpose     : sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) on a chip-select/write bus.
// Latency     : write sampled at edge 0 -> oBCD/oValid updated at edge DATA_W (16 cycles with defaults).
// Backpressure: none queued; writes arriving while oBusy=1 are silently dropped, firmware polls oBusy/oValid.
//
// Ports
//   iClk            clock, all state on the rising edge
//   iReset          asynchronous, active-high reset
//   iChip_select_n  active-low chip select
//   iWrite_n        active-low write strobe
//   iData           write data, only [DATA_W-1:0] is converted
//   oBCD            {zeros, digit[DIGITS-1] .. digit[0]}, digit[0] in [3:0]; holds last result
//   oBusy           conversion in progress
//   oValid          one-cycle pulse when oBCD has just been updated
//
// DATA_W/DIGITS must satisfy DIGITS*4 <= 32 and 10**DIGITS > 2**DATA_W-1 so the
// largest input always fits in the digit field.

`timescale 1ns/1ps

module bcd_converter #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iChip_select_n,
    input  logic        iWrite_n,
    input  logic [31:0] iData,
    output logic [31:0] oBCD,
    output logic        oBusy,
    output logic        oValid
);

    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                    r_state;
    logic [DATA_W-1:0]         r_bin;
    logic [BCD_W-1:0]          r_bcd;
    logic [CNT_W-1:0]          r_cnt;

    logic                      w_wr_accept;
    logic [BCD_W-1:0]          w_bcd_adj;
    logic [BCD_W+DATA_W-1:0]   w_shifted;

    // Bus strobe; only acted on while idle, so busy-time writes vanish.
    assign w_wr_accept = ~iChip_select_n & ~iWrite_n;

    // Add-3 correction on every digit in parallel: a digit >= 5 would
    // exceed 9 after the following doubling, so pre-bias it by 3 so the
    // shift carries cleanly into the next digit.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[d*4 +: 4] >= 4'd5) begin
                w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
            end
        end
    end

    // One iteration: corrected BCD field and remaining binary shift left as one word.
    assign w_shifted = {w_bcd_adj, r_bin} << 1;

    // Upper data bits are intentionally ignored.
    generate
        if (DATA_W < 32) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^iData[31:DATA_W];
        end
    endgenerate

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_state <= ST_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            oBCD    <= '0;
            oBusy   <= 1'b0;
            oValid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Clears the completion pulse; a write landing on the
                    // pulse cycle is accepted here as well.
                    oValid <= 1'b0;
                    if (w_wr_accept) begin
                        r_bin   <= iData[DATA_W-1:0];
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        oBusy   <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    r_bcd  <= w_shifted[BCD_W+DATA_W-1:DATA_W];
                    r_bin  <= w_shifted[DATA_W-1:0];
                    r_cnt  <= r_cnt + CNT_W'(1);
                    oValid <= 1'b0;
                    // Only the finished value reaches oBCD, so the
                    // displays never see intermediate digits.
                    if (r_cnt == LAST_ITER) begin
                        oBCD    <= 32'(w_shifted[BCD_W+DATA_W-1:DATA_W]);
                        oValid  <= 1'b1;
                        oBusy   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_converter.sv
`timescale 1ns/1ps

module tb_bcd_converter;

    localparam int DATA_W  = 16;
    localparam int DIGITS  = 5;
    localparam int LATENCY = DATA_W;
    localparam int TIMEOUT = 40;

    logic        clk;
    logic        rst;
    logic        cs_n;
    logic        wr_n;
    logic [31:0] data;
    logic [31:0] bcd;
    logic        busy;
    logic        valid;

    int vectors;
    int miscompares;

    bcd_converter #(
        .DATA_W(DATA_W),
        .DIGITS(DIGITS)
    ) dut (
        .iClk          (clk),
        .iReset        (rst),
        .iChip_select_n(cs_n),
        .iWrite_n      (wr_n),
        .iData         (data),
        .oBCD          (bcd),
        .oBusy         (busy),
        .oValid        (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by repeated division of the low DATA_W bits.
    function automatic logic [31:0] ref_bcd(input logic [31:0] v);
        int unsigned n;
        logic [31:0] r;
        n = v % (32'd1 << DATA_W);
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r = r | ((n % 10) << (4 * d));
            n = n / 10;
        end
        return r;
    endfunction

    // Drive a write strobe from the current negedge; returns one negedge later,
    // i.e. just after the edge that sampled it.
    task automatic pulse_write(input logic [31:0] v);
        cs_n = 1'b0;
        wr_n = 1'b0;
        data = v;
        @(negedge clk);
        cs_n = 1'b1;
        wr_n = 1'b1;
        data = $urandom;
    endtask

    task automatic do_write(input logic [31:0] v);
        @(negedge clk);
        pulse_write(v);
    endtask

    // Counts edges until oValid is seen; lat = 0 on timeout. Also reports
    // whether oBCD moved away from 'hold' before the pulse.
    task automatic wait_valid(input logic [31:0] hold, output int lat, output bit moved);
        lat   = 0;
        moved = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                lat = i;
                break;
            end
            if (bcd !== hold) moved = 1'b1;
        end
    endtask

    task automatic run_conv(input logic [31:0] v, input string name);
        logic [31:0] exp;
        logic [31:0] prev;
        int          lat;
        bit          moved;
        exp  = ref_bcd(v);
        prev = bcd;
        do_write(v);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_write: got %b want 1", name, busy);
        end
        wait_valid(prev, lat, moved);
        vectors++;
        if (lat != LATENCY) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, LATENCY);
        end
        vectors++;
        if (moved) begin
            miscompares++;
            $display("FAIL %s partial_value: oBCD changed before oValid", name);
        end
        vectors++;
        if (bcd !== exp) begin
            miscompares++;
            $display("FAIL %s result: got %h want %h", name, bcd, exp);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_at_valid: got %b want 0", name, busy);
        end
        @(negedge clk);
        vectors++;
        if (valid !== 1'b0 || bcd !== exp) begin
            miscompares++;
            $display("FAIL %s pulse_hold: valid %b bcd %h want 0 %h", name, valid, bcd, exp);
        end
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        cs_n = 1'b1;
        wr_n = 1'b1;
        data = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bcd !== 32'h0 || busy !== 1'b0 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: bcd %h busy %b valid %b want 0 0 0", bcd, busy, valid);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bcd !== 32'h0 || busy !== 1'b0 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: bcd %h busy %b valid %b want 0 0 0", bcd, busy, valid);
        end
    endtask

    task automatic test_known;
        run_conv(32'h0000_04D2, "w1234");
        vectors++;
        if (bcd !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL w1234_const: got %h want 00001234", bcd);
        end
        run_conv(32'hFFFF_FFFF, "wmax");
        vectors++;
        if (bcd !== 32'h0006_5535) begin
            miscompares++;
            $display("FAIL wmax_const: got %h want 00065535", bcd);
        end
        run_conv(32'h0, "wzero");
    endtask

    task automatic test_boundaries;
        logic [31:0] vals [4];
        vals = '{32'd9, 32'd10, 32'd99, 32'd100};
        foreach (vals[k]) run_conv(vals[k], $sformatf("bnd%0d", vals[k]));
    endtask

    task automatic test_mid_reset;
        bit pulsed;
        run_conv(32'd4321, "pre_reset");
        do_write(32'd1234);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (bcd !== 32'h0 || busy !== 1'b0 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: bcd %h busy %b valid %b want 0 0 0", bcd, busy, valid);
        end
        @(negedge clk);
        rst = 1'b0;
        pulsed = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (valid !== 1'b0 || busy !== 1'b0 || bcd !== 32'h0) pulsed = 1'b1;
        end
        vectors++;
        if (pulsed) begin
            miscompares++;
            $display("FAIL mid_reset_aftermath: activity after abort, bcd %h", bcd);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] prev;
        int          lat;
        bit          moved;
        prev = bcd;
        do_write(32'd42);
        repeat (7) @(negedge clk);
        pulse_write(32'd77);   // sampled at edge 8, while busy
        wait_valid(prev, lat, moved);
        vectors++;
        if (lat != LATENCY - 8) begin
            miscompares++;
            $display("FAIL busy_write_latency: got %0d want %0d", lat, LATENCY - 8);
        end
        vectors++;
        if (bcd !== 32'h0000_0042) begin
            miscompares++;
            $display("FAIL busy_write_ignored: got %h want 00000042", bcd);
        end
        // Write during the oValid cycle is accepted.
        prev = bcd;
        pulse_write(32'd77);
        vectors++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL valid_cycle_write: valid %b busy %b want 0 1", valid, busy);
        end
        wait_valid(prev, lat, moved);
        vectors++;
        if (lat != LATENCY || bcd !== 32'h0000_0077) begin
            miscompares++;
            $display("FAIL valid_cycle_result: lat %0d bcd %h want %0d 00000077", lat, bcd, LATENCY);
        end
        @(negedge clk);
    endtask

    task automatic test_no_strobe;
        logic [31:0] prev;
        bit          bad;
        prev = bcd;
        bad  = 1'b0;
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b1; data = 32'd555;
        repeat (3) begin
            @(negedge clk);
            if (busy !== 1'b0 || valid !== 1'b0 || bcd !== prev) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL cs_only: busy %b bcd %h want 0 %h", busy, bcd, prev);
        end
        bad  = 1'b0;
        cs_n = 1'b1; wr_n = 1'b0; data = 32'd666;
        repeat (3) begin
            @(negedge clk);
            if (busy !== 1'b0 || valid !== 1'b0 || bcd !== prev) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL wr_only: busy %b bcd %h want 0 %h", busy, bcd, prev);
        end
        cs_n = 1'b1; wr_n = 1'b1;
        repeat (20) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || bcd !== prev) begin
            miscompares++;
            $display("FAIL no_strobe_late: busy %b bcd %h want 0 %h", busy, bcd, prev);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 20; n++) begin
            run_conv($urandom, $sformatf("rnd%0d", n));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_known();
        test_boundaries();
        test_no_strobe();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
